// File: rtl/pwm_pkg.sv
// Shared types and defaults for the PWM capture path.
// The counter width is sized so one generator period (2048 clk) fits
// with headroom, and the default timeout is the largest count that fits.
package pwm_pkg;

  // Period of the companion PWM generator, in clk cycles.
  localparam int GEN_PERIOD  = 2048;
  localparam int CNT_W_DEF   = $clog2(GEN_PERIOD) + 1;
  localparam int TIMEOUT_DEF = (2 ** CNT_W_DEF) - 1;

  typedef enum logic [1:0] {
    WAIT_RISE = 2'd0,
    HIGH      = 2'd1,
    LOW       = 2'd2
  } cap_state_t;

endpackage

// File: rtl/pwm_sync_edge.sv
// Purpose: two-flop synchronizer plus delay flop with edge strobes for one async input.
// Latency: lvl_o follows async_i after two clk edges; rise_o/fall_o are combinational from lvl_o.
// Backpressure: none; free-running sampler.
// Ports: clk_i/rst_i (sync active-high), async_i raw input,
//        lvl_o synchronized level, rise_o/fall_o one-cycle edge strobes.
module pwm_sync_edge (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic lvl_o,
  output logic rise_o,
  output logic fall_o
);

  logic s1_q, s2_q, d_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      d_q  <= 1'b0;
    end else begin
      s1_q <= async_i;
      s2_q <= s1_q;
      d_q  <= s2_q;
    end
  end

  assign lvl_o  = s2_q;
  assign rise_o = s2_q & ~d_q;
  assign fall_o = ~s2_q & d_q;

endmodule

// File: rtl/pwm_capture.sv
// Purpose: measure high time and period of an async PWM line, flag stuck-high/low.
// Latency: meas_vld is registered, one edge after the synchronized rise (three edges after first sample).
// Backpressure: none; meas_vld is a one-cycle pulse the consumer must take.
// Ports: clk/rst (sync active-high), PWM_in raw waveform; duty_cnt/period_cnt last
//        complete measurement, meas_vld update strobe, timeout/stuck_hi status
//        levels, PWM_lvl synchronized copy of PWM_in.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             PWM_in,
  output logic [CNT_W-1:0] duty_cnt,
  output logic [CNT_W-1:0] period_cnt,
  output logic             meas_vld,
  output logic             timeout,
  output logic             stuck_hi,
  output logic             PWM_lvl
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] TO_LIM  = CNT_W'(TIMEOUT);

  logic lvl, rise, fall;

  pwm_sync_edge u_sync (
    .clk_i  (clk),
    .rst_i  (rst),
    .async_i(PWM_in),
    .lvl_o  (lvl),
    .rise_o (rise),
    .fall_o (fall)
  );

  cap_state_t       state_q, state_d;
  logic [CNT_W-1:0] hi_cnt_q, hi_cnt_d;
  logic [CNT_W-1:0] per_cnt_q, per_cnt_d;
  logic [CNT_W-1:0] duty_q, duty_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             vld_q, vld_d;
  logic             to_q, to_d;
  logic             sh_q, sh_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= WAIT_RISE;
      hi_cnt_q  <= '0;
      per_cnt_q <= '0;
      duty_q    <= '0;
      period_q  <= '0;
      vld_q     <= 1'b0;
      to_q      <= 1'b0;
      sh_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      hi_cnt_q  <= hi_cnt_d;
      per_cnt_q <= per_cnt_d;
      duty_q    <= duty_d;
      period_q  <= period_d;
      vld_q     <= vld_d;
      to_q      <= to_d;
      sh_q      <= sh_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    hi_cnt_d  = hi_cnt_q;
    per_cnt_d = per_cnt_q;
    duty_d    = duty_q;
    period_d  = period_q;
    vld_d     = 1'b0;
    to_d      = to_q;
    sh_d      = sh_q;

    unique case (state_q)
      WAIT_RISE: begin
        // First rise after reset or timeout only arms the measurement.
        if (rise) begin
          state_d   = HIGH;
          hi_cnt_d  = CNT_ONE;
          per_cnt_d = CNT_ONE;
        end
      end

      HIGH: begin
        // A rise cannot occur here (a fall must come first), so the
        // timeout check needs no rise qualification in this state.
        if (per_cnt_q == TO_LIM) begin
          state_d = WAIT_RISE;
          to_d    = 1'b1;
          sh_d    = 1'b1;
        end else begin
          per_cnt_d = per_cnt_q + CNT_ONE;
          if (fall) begin
            state_d = LOW;
          end else if (lvl) begin
            hi_cnt_d = hi_cnt_q + CNT_ONE;
          end
        end
      end

      LOW: begin
        // Rise wins over timeout, so a period of exactly TIMEOUT publishes.
        if (rise) begin
          duty_d    = hi_cnt_q;
          period_d  = per_cnt_q;
          vld_d     = 1'b1;
          to_d      = 1'b0;
          sh_d      = 1'b0;
          hi_cnt_d  = CNT_ONE;
          per_cnt_d = CNT_ONE;
          state_d   = HIGH;
        end else if (per_cnt_q == TO_LIM) begin
          state_d = WAIT_RISE;
          to_d    = 1'b1;
          sh_d    = 1'b0;
        end else begin
          per_cnt_d = per_cnt_q + CNT_ONE;
        end
      end

      default: state_d = WAIT_RISE;
    endcase
  end

  assign duty_cnt   = duty_q;
  assign period_cnt = period_q;
  assign meas_vld   = vld_q;
  assign timeout    = to_q;
  assign stuck_hi   = sh_q;
  assign PWM_lvl    = lvl;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: square waves, timeouts, boundary periods,
// mid-measurement reset and input-to-strobe latency.
module tb_pwm_capture;

  logic        clk;
  logic        rst;
  logic        PWM_in;
  logic [11:0] duty_cnt;
  logic [11:0] period_cnt;
  logic        meas_vld;
  logic        timeout;
  logic        stuck_hi;
  logic        PWM_lvl;

  int vectors;
  int miscompares;
  int cyc;

  int pulse_cyc[$];
  int pulse_duty[$];
  int pulse_per[$];
  int pulse_to[$];
  int pulse_sh[$];
  int to_rise_cyc;
  logic to_prev;

  pwm_capture #(.CNT_W(12), .TIMEOUT(4095)) dut (
    .clk       (clk),
    .rst       (rst),
    .PWM_in    (PWM_in),
    .duty_cnt  (duty_cnt),
    .period_cnt(period_cnt),
    .meas_vld  (meas_vld),
    .timeout   (timeout),
    .stuck_hi  (stuck_hi),
    .PWM_lvl   (PWM_lvl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  // Log every publish and the first timeout assertion, sampled mid-cycle.
  initial begin
    to_rise_cyc = -1;
    to_prev = 1'b0;
  end
  always @(negedge clk) begin
    if (meas_vld === 1'b1) begin
      pulse_cyc.push_back(cyc);
      pulse_duty.push_back(int'(duty_cnt));
      pulse_per.push_back(int'(period_cnt));
      pulse_to.push_back(int'(timeout));
      pulse_sh.push_back(int'(stuck_hi));
    end
    if (timeout === 1'b1 && to_prev !== 1'b1 && to_rise_cyc < 0) to_rise_cyc = cyc;
    to_prev = timeout;
  end

  task automatic clr_log();
    pulse_cyc.delete();
    pulse_duty.delete();
    pulse_per.delete();
    pulse_to.delete();
    pulse_sh.delete();
    to_rise_cyc = -1;
  endtask

  // Called at a negedge, returns at a negedge: PWM_in high for hi edges, period per edges.
  task automatic drive_period(input int hi, input int per);
    PWM_in = 1'b1;
    repeat (hi) @(negedge clk);
    PWM_in = 1'b0;
    repeat (per - hi) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    PWM_in = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    clr_log();
  endtask

  task automatic test_reset();
    do_reset();
    vectors++; if (duty_cnt !== 12'd0) begin miscompares++; $display("FAIL reset_duty: got %0d expected 0", duty_cnt); end
    vectors++; if (period_cnt !== 12'd0) begin miscompares++; $display("FAIL reset_period: got %0d expected 0", period_cnt); end
    vectors++; if (meas_vld !== 1'b0) begin miscompares++; $display("FAIL reset_vld: got %b expected 0", meas_vld); end
    vectors++; if (timeout !== 1'b0) begin miscompares++; $display("FAIL reset_timeout: got %b expected 0", timeout); end
    vectors++; if (stuck_hi !== 1'b0) begin miscompares++; $display("FAIL reset_stuck_hi: got %b expected 0", stuck_hi); end
    vectors++; if (PWM_lvl !== 1'b0) begin miscompares++; $display("FAIL reset_lvl: got %b expected 0", PWM_lvl); end
  endtask

  task automatic test_square();
    do_reset();
    repeat (4) drive_period(512, 2048);
    repeat (5) @(negedge clk);
    vectors++; if (pulse_cyc.size() !== 3) begin miscompares++; $display("FAIL sq_pulses: got %0d expected 3", pulse_cyc.size()); end
    for (int i = 1; i < pulse_cyc.size(); i++) begin
      vectors++; if (pulse_cyc[i] - pulse_cyc[i-1] !== 2048) begin miscompares++; $display("FAIL sq_spacing%0d: got %0d expected 2048", i, pulse_cyc[i] - pulse_cyc[i-1]); end
    end
    for (int i = 0; i < pulse_duty.size(); i++) begin
      vectors++; if (pulse_duty[i] !== 512) begin miscompares++; $display("FAIL sq_duty%0d: got %0d expected 512", i, pulse_duty[i]); end
      vectors++; if (pulse_per[i] !== 2048) begin miscompares++; $display("FAIL sq_period%0d: got %0d expected 2048", i, pulse_per[i]); end
      vectors++; if (pulse_to[i] !== 0) begin miscompares++; $display("FAIL sq_timeout%0d: got %0d expected 0", i, pulse_to[i]); end
    end
    vectors++; if (meas_vld !== 1'b0) begin miscompares++; $display("FAIL sq_vld_idle: got %b expected 0", meas_vld); end
  endtask

  task automatic test_idle_timeout();
    int n;
    do_reset();
    repeat (5000) @(negedge clk);
    vectors++; if (pulse_cyc.size() !== 0) begin miscompares++; $display("FAIL idle_pulses: got %0d expected 0", pulse_cyc.size()); end
    vectors++; if (timeout !== 1'b0) begin miscompares++; $display("FAIL idle_no_rise_timeout: got %b expected 0", timeout); end
    n = cyc;
    PWM_in = 1'b1;
    repeat (10) @(negedge clk);
    PWM_in = 1'b0;
    repeat (4200) @(negedge clk);
    // Sampled at edge n+1, s2 at n+2, armed at n+3, per_cnt=4095 after n+4097.
    vectors++; if (to_rise_cyc !== n + 4098) begin miscompares++; $display("FAIL low_timeout_cycle: got %0d expected %0d", to_rise_cyc, n + 4098); end
    vectors++; if (timeout !== 1'b1) begin miscompares++; $display("FAIL low_timeout: got %b expected 1", timeout); end
    vectors++; if (stuck_hi !== 1'b0) begin miscompares++; $display("FAIL low_stuck_hi: got %b expected 0", stuck_hi); end
    vectors++; if (pulse_cyc.size() !== 0) begin miscompares++; $display("FAIL low_pulses: got %0d expected 0", pulse_cyc.size()); end
  endtask

  task automatic test_stuck_hi();
    do_reset();
    PWM_in = 1'b1;
    repeat (4200) @(negedge clk);
    vectors++; if (timeout !== 1'b1) begin miscompares++; $display("FAIL sh_timeout: got %b expected 1", timeout); end
    vectors++; if (stuck_hi !== 1'b1) begin miscompares++; $display("FAIL sh_stuck_hi: got %b expected 1", stuck_hi); end
    vectors++; if (pulse_cyc.size() !== 0) begin miscompares++; $display("FAIL sh_pulses: got %0d expected 0", pulse_cyc.size()); end
    PWM_in = 1'b0;
    repeat (20) @(negedge clk);
    drive_period(1000, 2048);
    vectors++; if (pulse_cyc.size() !== 0) begin miscompares++; $display("FAIL sh_rearm_pulse: got %0d expected 0", pulse_cyc.size()); end
    vectors++; if (timeout !== 1'b1) begin miscompares++; $display("FAIL sh_timeout_held: got %b expected 1", timeout); end
    drive_period(1000, 2048);
    vectors++; if (pulse_cyc.size() !== 1) begin miscompares++; $display("FAIL sh_resume_pulses: got %0d expected 1", pulse_cyc.size()); end
    for (int i = 0; i < pulse_cyc.size(); i++) begin
      vectors++; if (pulse_duty[i] !== 1000) begin miscompares++; $display("FAIL sh_resume_duty: got %0d expected 1000", pulse_duty[i]); end
      vectors++; if (pulse_per[i] !== 2048) begin miscompares++; $display("FAIL sh_resume_period: got %0d expected 2048", pulse_per[i]); end
      vectors++; if (pulse_to[i] !== 0) begin miscompares++; $display("FAIL sh_clear_timeout: got %0d expected 0", pulse_to[i]); end
      vectors++; if (pulse_sh[i] !== 0) begin miscompares++; $display("FAIL sh_clear_stuck: got %0d expected 0", pulse_sh[i]); end
    end
  endtask

  task automatic test_boundary();
    do_reset();
    drive_period(100, 4095);
    drive_period(100, 4096);
    PWM_in = 1'b1;
    repeat (10) @(negedge clk);
    vectors++; if (pulse_cyc.size() !== 1) begin miscompares++; $display("FAIL bnd_pulses: got %0d expected 1", pulse_cyc.size()); end
    for (int i = 0; i < pulse_cyc.size(); i++) begin
      vectors++; if (pulse_per[i] !== 4095) begin miscompares++; $display("FAIL bnd_period_4095: got %0d expected 4095", pulse_per[i]); end
      vectors++; if (pulse_duty[i] !== 100) begin miscompares++; $display("FAIL bnd_duty: got %0d expected 100", pulse_duty[i]); end
    end
    vectors++; if (timeout !== 1'b1) begin miscompares++; $display("FAIL bnd_timeout_4096: got %b expected 1", timeout); end
    vectors++; if (stuck_hi !== 1'b0) begin miscompares++; $display("FAIL bnd_stuck_hi: got %b expected 0", stuck_hi); end
    vectors++; if (period_cnt !== 12'd4095) begin miscompares++; $display("FAIL bnd_period_hold: got %0d expected 4095", period_cnt); end
    vectors++; if (duty_cnt !== 12'd100) begin miscompares++; $display("FAIL bnd_duty_hold: got %0d expected 100", duty_cnt); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive_period(500, 2048);
    PWM_in = 1'b1;
    repeat (100) @(negedge clk);
    rst = 1'b1;
    PWM_in = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    vectors++; if (duty_cnt !== 12'd0) begin miscompares++; $display("FAIL mid_duty: got %0d expected 0", duty_cnt); end
    vectors++; if (period_cnt !== 12'd0) begin miscompares++; $display("FAIL mid_period: got %0d expected 0", period_cnt); end
    vectors++; if (PWM_lvl !== 1'b0) begin miscompares++; $display("FAIL mid_lvl: got %b expected 0", PWM_lvl); end
    vectors++; if (meas_vld !== 1'b0) begin miscompares++; $display("FAIL mid_vld: got %b expected 0", meas_vld); end
    clr_log();
    repeat (50) @(negedge clk);
    drive_period(700, 2048);
    vectors++; if (pulse_cyc.size() !== 0) begin miscompares++; $display("FAIL mid_first_rise: got %0d expected 0", pulse_cyc.size()); end
    drive_period(700, 2048);
    vectors++; if (pulse_cyc.size() !== 1) begin miscompares++; $display("FAIL mid_second_rise: got %0d expected 1", pulse_cyc.size()); end
    for (int i = 0; i < pulse_cyc.size(); i++) begin
      vectors++; if (pulse_duty[i] !== 700) begin miscompares++; $display("FAIL mid_duty_pub: got %0d expected 700", pulse_duty[i]); end
      vectors++; if (pulse_per[i] !== 2048) begin miscompares++; $display("FAIL mid_period_pub: got %0d expected 2048", pulse_per[i]); end
    end
  endtask

  task automatic test_latency();
    do_reset();
    drive_period(300, 1000);
    PWM_in = 1'b1;
    @(posedge clk); #1;
    vectors++; if (PWM_lvl !== 1'b0) begin miscompares++; $display("FAIL lat_lvl_e1: got %b expected 0", PWM_lvl); end
    @(posedge clk); #1;
    vectors++; if (PWM_lvl !== 1'b1) begin miscompares++; $display("FAIL lat_lvl_e2: got %b expected 1", PWM_lvl); end
    vectors++; if (meas_vld !== 1'b0) begin miscompares++; $display("FAIL lat_vld_e2: got %b expected 0", meas_vld); end
    @(posedge clk); #1;
    vectors++; if (meas_vld !== 1'b1) begin miscompares++; $display("FAIL lat_vld_e3: got %b expected 1", meas_vld); end
    vectors++; if (period_cnt !== 12'd1000) begin miscompares++; $display("FAIL lat_period: got %0d expected 1000", period_cnt); end
    vectors++; if (duty_cnt !== 12'd300) begin miscompares++; $display("FAIL lat_duty: got %0d expected 300", duty_cnt); end
    @(posedge clk); #1;
    vectors++; if (meas_vld !== 1'b0) begin miscompares++; $display("FAIL lat_vld_e4: got %b expected 0", meas_vld); end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1;
    PWM_in = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_square();
    test_idle_timeout();
    test_stuck_hi();
    test_boundary();
    test_reset_mid();
    test_latency();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
